// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the synchronous FIFO family
//
// Purpose : default geometry and a constant-foldable ceil(log2) used to size
//           pointers and the occupancy count.
// Ports   : none (package).

package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 8;

  // Smallest n with 2**n >= value; evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
//
// Purpose : groups the write side, read side and status of the FIFO.
// Signals : write_e, data_in          - write request and data
//           read_e                    - read request
//           data_out, data_valid      - registered read data and its strobe
//           full, empty, almost_full, almost_empty, count - occupancy status
//           overflow, underflow       - one-cycle error pulses
// Modports: master - the surrounding logic (drives requests, sees status)
//           slave  - the FIFO itself

interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
);

  localparam int AW = clog2(DEPTH);

  logic              write_e;
  logic [DATA_W-1:0] data_in;
  logic              read_e;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output write_e, data_in, read_e,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write_e, data_in, read_e,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W storage with one write and one registered read port
//
// Purpose : FIFO storage array. The array itself is never reset; only the
//           read data register is, so the FIFO output comes up at zero.
// Ports   : clk_i, reset_i          - clock, synchronous active-high reset
//           wr_en_i, wr_idx_i, wr_data_i - write port
//           rd_en_i, rd_idx_i       - read port; rd_data_o updates on the edge
//           rd_data_o               - registered read data, holds when idle

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with thresholds and error pulses
//
// Purpose : same-clock FIFO, all DEPTH entries usable, occupancy count,
//           programmable almost_full/almost_empty, read-valid strobe and
//           registered overflow/underflow pulses.
// Ports   : clk   - clock, all state on the rising edge
//           reset - synchronous active-high reset, overrides every request
//           bus   - sync_fifo_param_if.slave (requests in, data/status out)

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_param_if.slave   bus
);

  localparam int          AW  = clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        data_valid_q, data_valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  // Flags decode the registered count so they can never disagree with it.
  assign full  = (int'(count_q) == DEPTH);
  assign empty = (count_q == '0);

  assign wr_acc = bus.write_e && !full;
  assign rd_acc = bus.read_e && !empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = rd_acc;
    // Error pulses look at the pre-edge state: a write while full is an
    // overflow even if a read in the same cycle frees a slot.
    overflow_d   = bus.write_e && full;
    underflow_d  = bus.read_e && empty;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;

    if (wr_acc && !rd_acc) begin
      count_d = count_q + ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Requests in the reset cycle must not touch storage or the read register.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_acc && !reset),
    .wr_idx_i  (wr_ptr_q[AW-1:0]),
    .wr_data_i (bus.data_in),
    .rd_en_i   (rd_acc && !reset),
    .rd_idx_i  (rd_ptr_q[AW-1:0]),
    .rd_data_o (bus.data_out)
  );

  assign bus.data_valid   = data_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count_q) >= AF_LEVEL);
  assign bus.almost_empty = (int'(count_q) <= AE_LEVEL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the next generation of the team's 8x8 buffer: configurable data width and depth, all DEPTH entries usable, occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe and overflow/underflow error pulses. It sits between any two same-clock producer/consumer blocks in the sequential-circuit library. It replaces the fixed 8x8 FIFO in new designs.

## Interface
- DATA_W, 8, data word width (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; priority over all other inputs
- write_e  in  1  write request
- data_in  in  DATA_W  write data
- read_e  in  1  read request
- data_out  out  DATA_W  registered read data
- data_valid  out  1  1-cycle pulse: data_out holds a newly read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1 (AW = log2(DEPTH))  occupancy, 0..DEPTH
- overflow  out  1  1-cycle pulse: write_e while full
- underflow  out  1  1-cycle pulse: read_e while empty

## Operation
- Write accepted iff write_e && !full; read accepted iff read_e && !empty. full/empty are sampled at the start of the cycle (pre-edge state).
- Pointers are AW+1 bits wide; index = low AW bits; wrap from DEPTH-1 to 0 is natural modulo arithmetic. Full = MSBs differ, low bits equal. No entry is sacrificed.
- Accepted write: mem[wr_idx] <= data_in; wr_ptr += 1.
- Accepted read: data_out <= mem[rd_idx]; rd_ptr += 1; data_valid <= 1. Otherwise data_valid <= 0 and data_out holds its value.
- count: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Simultaneous read+write, non-empty and non-full: both accepted, count unchanged.
- Both requested when full: read accepted, write rejected, overflow pulses.
- Both requested when empty: write accepted, read rejected, underflow pulses; data_out unchanged.
- Rejected requests change no state other than the error pulse.
- Flags (full, empty, almost_*) are combinational decodes of the registered count, so they are always consistent with count.

## Timing
- Reset values: wr_ptr=rd_ptr=0, count=0, data_out=0, data_valid=0, overflow=underflow=0. Hence empty=1, full=0, almost_empty=1 (while AE_LEVEL>=0), almost_full=0. Memory contents are not reset.
- A reset asserted mid-operation discards all contents on that edge. Requests in the reset cycle are ignored, with no error pulses.
- Write latency: a word written at edge N is readable by a read request at edge N+1 (empty deasserts after edge N).
- Read latency: 1 cycle. The word appears on data_out, with data_valid=1, right after the edge that accepts the read.
- Error pulses are registered: high for exactly the cycle after the offending edge.

## Structure
- Shared package fifo_pkg: function clog2 for AW, and the defaults FIFO_DATA_W_DEF=8 and FIFO_DEPTH_DEF=8.
- One sub-module, fifo_mem: DEPTH x DATA_W array with 1 synchronous write port and 1 synchronous registered read port.
- The top level holds pointers, count, flags and error logic.

## Test plan
- Reset, then fill: write 8 words 0x11..0x88 -> count steps 1..8; almost_full at count 7; full at count 8; empty=0 after the first edge.
- Drain: 8 reads -> data_out=0x11..0x88 in order, each with a one-cycle data_valid; empty=1 and count=0 after the 8th; almost_empty at count<=1.
- Overflow/underflow: write 0x99 while full -> overflow pulses, count stays 8, 0x99 is never read. Read while empty -> underflow pulses, data_out holds 0x88.
- Wrap and simultaneous access: prefill 3 words, then 20 cycles of read+write with an incrementing pattern -> count stays 3, data stays in order across pointer wrap, no error pulses. Read+write when full -> read 0xA1 returned, write rejected, overflow pulses.
- Mid-operation reset with count=5 -> next cycle count=0, empty=1, data_out=0, data_valid=0. A following write of 0x5A then a read returns 0x5A.
- Parameter sweep: DATA_W=16/DEPTH=16 and DEPTH=2, with AF_LEVEL=12 and AE_LEVEL=4 -> flags assert at exactly those counts; full at 16 and 2 respectively.
